// File: rtl/osr_pull_controller.sv
// OSR / TX FIFO sequencer for one state machine: decodes OUT, PULL and MOV-to-OSR into
// registered OSR strobes and FIFO pops, applying the blocking and autopull stall rules.
module osr_pull_controller #(
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [1:0]        instr_op,
  input  logic [4:0]        out_count,
  input  logic              pull_block,
  input  logic              pull_ifempty,
  input  logic              autopull,
  input  logic [4:0]        pull_thresh,
  input  logic [5:0]        osr_count,
  input  logic [31:0]       x_in,
  input  logic [31:0]       mov_data,
  input  logic              fifo_empty,
  input  logic [31:0]       fifo_data,
  output logic              fifo_pop,
  output logic              stall,
  output logic              osr_mov_en,
  output logic [31:0]       osr_mov_data,
  output logic              osr_fifo_pull,
  output logic              osr_shift_en,
  output logic [4:0]        osr_shift_cnt,
  output logic [31:0]       osr_fifo_data,
  output logic [STAT_W-1:0] stall_cycles,
  output logic [STAT_W-1:0] pull_total
);

  typedef enum logic [1:0] {StIdle, StPullWait, StAutoWait} state_e;

  localparam logic [1:0] OpNop  = 2'd0;
  localparam logic [1:0] OpOut  = 2'd1;
  localparam logic [1:0] OpPull = 2'd2;
  localparam logic [1:0] OpMov  = 2'd3;

  state_e state_q, state_d;

  logic [5:0]  thr, cnt;
  logic [6:0]  shifted_sum;
  logic        refill_due, auto_stall, ifempty_skip;
  logic        mov_d, pull_d, shift_d;
  logic [31:0] mov_src;

  logic              mov_en_q, pull_q, shift_en_q;
  logic [31:0]       mov_data_q, fifo_data_q;
  logic [4:0]        shift_cnt_q;
  logic [STAT_W-1:0] stall_cycles_q, pull_total_q;

  always_comb begin
    thr = (pull_thresh == 5'd0) ? 6'd32 : {1'b0, pull_thresh};
    cnt = (out_count == 5'd0) ? 6'd32 : {1'b0, out_count};
    // thr never exceeds 32, so min(sum,32) >= thr reduces to sum >= thr.
    shifted_sum  = {1'b0, osr_count} + {1'b0, cnt};
    refill_due   = autopull && (shifted_sum >= {1'b0, thr});
    auto_stall   = autopull && (osr_count >= thr) && fifo_empty;
    ifempty_skip = pull_ifempty && (osr_count < thr);
  end

  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    fifo_pop = 1'b0;
    mov_d    = 1'b0;
    mov_src  = mov_data;
    pull_d   = 1'b0;
    shift_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (instr_valid) begin
          unique case (instr_op)
            OpNop: ;
            OpMov: mov_d = 1'b1;
            OpPull: begin
              if (ifempty_skip) begin
                // threshold not reached: PULL IFEMPTY retires as a no-op
              end else if (!fifo_empty) begin
                fifo_pop = 1'b1;
                pull_d   = 1'b1;
              end else if (!pull_block) begin
                mov_d   = 1'b1;
                mov_src = x_in;
              end else begin
                stall   = 1'b1;
                state_d = StPullWait;
              end
            end
            OpOut: begin
              if (auto_stall) begin
                stall   = 1'b1;
                state_d = StAutoWait;
              end else begin
                shift_d  = 1'b1;
                fifo_pop = refill_due && !fifo_empty;
              end
            end
          endcase
        end
      end
      StPullWait: begin
        if (!instr_valid) begin
          state_d = StIdle;
        end else if (fifo_empty) begin
          stall = 1'b1;
        end else begin
          fifo_pop = 1'b1;
          pull_d   = 1'b1;
          state_d  = StIdle;
        end
      end
      StAutoWait: begin
        if (!instr_valid) begin
          state_d = StIdle;
        end else if (fifo_empty) begin
          stall = 1'b1;
        end else begin
          shift_d  = 1'b1;
          fifo_pop = refill_due;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      mov_en_q       <= 1'b0;
      pull_q         <= 1'b0;
      shift_en_q     <= 1'b0;
      mov_data_q     <= '0;
      fifo_data_q    <= '0;
      shift_cnt_q    <= '0;
      stall_cycles_q <= '0;
      pull_total_q   <= '0;
    end else begin
      state_q    <= state_d;
      mov_en_q   <= mov_d;
      pull_q     <= pull_d;
      shift_en_q <= shift_d;
      if (mov_d)    mov_data_q  <= mov_src;
      if (fifo_pop) fifo_data_q <= fifo_data;
      if (shift_d)  shift_cnt_q <= out_count;
      if (stall && (stall_cycles_q != '1)) stall_cycles_q <= stall_cycles_q + 1'b1;
      if (fifo_pop) pull_total_q <= pull_total_q + 1'b1;
    end
  end

  assign osr_mov_en    = mov_en_q;
  assign osr_mov_data  = mov_data_q;
  assign osr_fifo_pull = pull_q;
  assign osr_shift_en  = shift_en_q;
  assign osr_shift_cnt = shift_cnt_q;
  assign osr_fifo_data = fifo_data_q;
  assign stall_cycles  = stall_cycles_q;
  assign pull_total    = pull_total_q;

endmodule
